// File: rtl/aia_csr_resp.sv
// ---------------------------------------------------------------------------
// aia_csr_resp
//
// CSR target endpoint on the AIA side of the core CSR bus. Accepts a
// request (address, op, funct3, zimm, rs1 value), performs the RISC-V
// CSRRW/CSRRS/CSRRC read-modify-write on a small AIA register set and
// returns the pre-write value with a normal/exception status. The
// response is registered and held until the requester acknowledges it.
//
// Register set:
//   miselect (0x350) : 8 implemented bits, upper bits read 0
//   mireg    (0x351) : indirect window onto bank[miselect - 0x70],
//                      valid for miselect in 0x70..0x77
//   mtopi    (0xFB0) : read-only, [23:16] = lowest nonzero bank index + 1
//
// Ports:
//   clk          clock
//   rst          synchronous reset, active-high
//   aia_reg_en   request valid (sampled only while idle)
//   aia_addr     CSR address
//   aia_reg_op   [1] = read, [0] = write
//   aia_funct3   CSR instruction funct3
//   aia_csr_imm  zimm operand
//   aia_rs1_val  rs1 operand
//   aia_rrsp     requester accepts the response
//   aia_rvalid   response valid
//   aia_rdata    old CSR value (0 on exception)
//   aia_act_rsp  0 = normal, 1 = exception
//
// Optional feature macro: AIA_CSR_RESP_TIMEOUT_EN
//   When defined, an unacknowledged response is dropped after 256 cycles
//   in RESP. Any write committed at acceptance stays committed.
// ---------------------------------------------------------------------------
module aia_csr_resp #(
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  aia_reg_en,
  input  logic [ADDR_WIDTH-1:0] aia_addr,
  input  logic [1:0]            aia_reg_op,
  input  logic [2:0]            aia_funct3,
  input  logic [4:0]            aia_csr_imm,
  input  logic [REG_WIDTH-1:0]  aia_rs1_val,
  input  logic                  aia_rrsp,
  output logic                  aia_rvalid,
  output logic [REG_WIDTH-1:0]  aia_rdata,
  output logic                  aia_act_rsp
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MISELECT = ADDR_WIDTH'(12'h350);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MIREG    = ADDR_WIDTH'(12'h351);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MTOPI    = ADDR_WIDTH'(12'hFB0);

  typedef enum logic {IDLE, RESP} state_t;

  state_t                      state_reg, state_next;
  logic [7:0]                  miselect_reg;
  logic [REG_WIDTH-1:0]        rdata_reg;
  logic                        act_rsp_reg;
  logic [7:0][REG_WIDTH-1:0]   bank_rd;
  logic [7:0]                  bank_nz;

  logic                        is_misel, is_mireg, is_mtopi;
  logic                        mireg_ok, exc, accept, do_write;
  logic [2:0]                  bank_idx;
  logic [3:0]                  prio;
  logic [REG_WIDTH-1:0]        mtopi_val, old_val, src, new_val;

  // ------------------------------------------------------------------
  // Decode
  // ------------------------------------------------------------------
  assign is_misel = (aia_addr == ADDR_MISELECT);
  assign is_mireg = (aia_addr == ADDR_MIREG);
  assign is_mtopi = (aia_addr == ADDR_MTOPI);

  // miselect in 0x70..0x77 <=> top five bits are 0b01110
  assign mireg_ok = (miselect_reg[7:3] == 5'b01110);
  assign bank_idx = miselect_reg[2:0];

  // Lowest nonzero entry wins, so scan from the top down.
  always_comb begin
    prio = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (bank_nz[i]) prio = 4'(i + 1);
    end
  end

  always_comb begin
    mtopi_val        = '0;
    mtopi_val[23:16] = {4'b0000, prio};
  end

  always_comb begin
    old_val = '0;
    if (is_misel)      old_val = REG_WIDTH'(miselect_reg);
    else if (is_mireg) old_val = bank_rd[bank_idx];
    else if (is_mtopi) old_val = mtopi_val;
  end

  assign src = aia_funct3[2] ? REG_WIDTH'(aia_csr_imm) : aia_rs1_val;

  always_comb begin
    new_val = src;
    case (aia_funct3[1:0])
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = src;
    endcase
  end

  assign exc = !(is_misel || is_mireg || is_mtopi)
             || (aia_funct3[1:0] == 2'b00)
             || (is_mtopi && aia_reg_op[0])
             || (is_mireg && !mireg_ok)
             || (aia_reg_op == 2'b00);

  assign accept   = (state_reg == IDLE) && aia_reg_en;
  assign do_write = accept && !exc && aia_reg_op[0];

  // ------------------------------------------------------------------
  // Register bank: one register per entry so mtopi can see all of them
  // ------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bank
      logic [REG_WIDTH-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (rst)
          entry_reg <= '0;
        else if (do_write && is_mireg && (bank_idx == 3'(gi)))
          entry_reg <= new_val;
      end
      assign bank_rd[gi] = entry_reg;
      assign bank_nz[gi] = |entry_reg;
    end
  endgenerate

`ifdef AIA_CSR_RESP_TIMEOUT_EN
  logic [7:0] cnt_reg;
  always_ff @(posedge clk) begin
    if (rst)                   cnt_reg <= 8'd0;
    else if (accept)           cnt_reg <= 8'd0;
    else if (state_reg == RESP) cnt_reg <= cnt_reg + 8'd1;
  end
`endif

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (aia_reg_en) state_next = RESP;
      RESP: begin
        if (aia_rrsp) state_next = IDLE;
`ifdef AIA_CSR_RESP_TIMEOUT_EN
        // 256th cycle in RESP without an acknowledge
        else if (cnt_reg == 8'hFF) state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      miselect_reg <= 8'd0;
      rdata_reg    <= '0;
      act_rsp_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        rdata_reg   <= exc ? '0 : old_val;
        act_rsp_reg <= exc;
      end
      if (do_write && is_misel) miselect_reg <= new_val[7:0];
    end
  end

  assign aia_rvalid  = (state_reg == RESP);
  assign aia_rdata   = rdata_reg;
  assign aia_act_rsp = act_rsp_reg;

endmodule
